// File: rtl/odd_range_sampler_ctrl.sv
// Two-requester sampler: draws LFSR candidates until one is odd and strictly inside (UNDERFLOW, OVERFLOW).
// Optional rejected-candidate counter enabled by defining ODD_RANGE_STATS_EN.
module odd_range_sampler_ctrl #(
  parameter int unsigned       WIDTH     = 7,
  parameter logic [WIDTH-1:0]  UNDERFLOW = WIDTH'(33),
  parameter logic [WIDTH-1:0]  OVERFLOW  = WIDTH'(66),
  parameter int unsigned       MAX_TRIES = 16,
  parameter logic [15:0]       SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      reject_cnt
);

  localparam int unsigned TRY_W = 8;
  localparam logic [15:0] TAPS  = 16'hB400;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [TRY_W-1:0] tries, tries_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic             last_id, last_id_nxt;
  logic             rsp_valid_nxt, rsp_id_nxt, rsp_err_nxt, busy_nxt;
  logic [WIDTH-1:0] rsp_data_nxt;
  logic [15:0]      lfsr_step;
  logic             accept;

  // Right-shifting Galois step
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  assign accept    = (cand > UNDERFLOW) && (cand < OVERFLOW) && cand[0];

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    tries_nxt     = tries;
    cand_nxt      = cand;
    last_id_nxt   = last_id;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_err_nxt   = rsp_err;
    rsp_data_nxt  = rsp_data;
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Tie goes to the requester not served last
          rsp_id_nxt = (req == 2'b11) ? ~last_id : req[1];
          tries_nxt  = '0;
          state_nxt  = S_DRAW;
        end
      end
      S_DRAW: begin
        lfsr_nxt  = lfsr_step;
        cand_nxt  = lfsr_step[WIDTH-1:0];
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = cand;
          state_nxt     = S_RESP;
        end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_data_nxt  = '0;
          state_nxt     = S_RESP;
        end else begin
          tries_nxt = tries + TRY_W'(1);
          state_nxt = S_DRAW;
        end
      end
      default: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          last_id_nxt   = rsp_id;
          state_nxt     = S_IDLE;
        end
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      tries     <= '0;
      cand      <= '0;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      tries     <= tries_nxt;
      cand      <= cand_nxt;
      last_id   <= last_id_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_data  <= rsp_data_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef ODD_RANGE_STATS_EN
  logic reject;
  assign reject = (state == S_CHECK) && !accept;

  // Saturating count of rejected candidates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_cnt <= 16'd0;
    end else if (reject && (reject_cnt != 16'hFFFF)) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`else
  assign reject_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_odd_range_sampler_ctrl.sv
// Scoreboarded bench: default-range instance plus an empty-range instance (UNDERFLOW=126, MAX_TRIES=4).
module tb_odd_range_sampler_ctrl;

  typedef struct {
    logic       id;
    logic       err;
    logic [6:0] data;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_d, req_e;
  logic       rdy_d, rdy_e;
  logic       v_d, v_e, id_d, id_e, err_d, err_e, busy_d, busy_e;
  logic [6:0] data_d, data_e;
  logic [15:0] rej_d, rej_e;

  bit          sel;
  logic        o_valid, o_id, o_err, o_busy;
  logic [6:0]  o_data;
  logic [15:0] o_rej;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [15:0] m_lfsr[2];
  logic        m_last[2];
  int          m_rej[2];
  int          lo[2] = '{33, 126};
  int          hi[2] = '{66, 66};
  int          mt[2] = '{16, 4};

  always #5 clk = ~clk;

  odd_range_sampler_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req(req_d), .rsp_valid(v_d), .rsp_ready(rdy_d),
    .rsp_id(id_d), .rsp_err(err_d), .rsp_data(data_d), .busy(busy_d), .reject_cnt(rej_d)
  );

  odd_range_sampler_ctrl #(.UNDERFLOW(7'd126), .MAX_TRIES(4)) u_empty (
    .clk(clk), .rst_n(rst_n), .req(req_e), .rsp_valid(v_e), .rsp_ready(rdy_e),
    .rsp_id(id_e), .rsp_err(err_e), .rsp_data(data_e), .busy(busy_e), .reject_cnt(rej_e)
  );

  always_comb begin
    o_valid = sel ? v_e    : v_d;
    o_id    = sel ? id_e   : id_d;
    o_err   = sel ? err_e  : err_d;
    o_data  = sel ? data_e : data_d;
    o_busy  = sel ? busy_e : busy_d;
    o_rej   = sel ? rej_e  : rej_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1;
      m_last[i] = 1'b1;
      m_rej[i]  = 0;
    end
  endtask

  task automatic set_req(input logic [1:0] r);
    if (sel) req_e = r; else req_d = r;
  endtask

  task automatic set_rdy(input logic r);
    if (sel) rdy_e = r; else rdy_d = r;
  endtask

  // Issue one request, hold off acceptance for `hold` cycles, optionally drop req after grant
  task automatic run_req(input logic [1:0] r, input int hold, input bit drop);
    exp_t        e, got;
    logic [15:0] lf;
    logic [6:0]  c;
    logic [6:0]  d0;
    logic        id0;
    bit          done;
    int          lat, s, exp_rej;
    s     = int'(sel);
    e.id  = (r == 2'b11) ? ~m_last[s] : r[1];
    e.err = 1'b1;
    e.data = 7'd0;
    e.lat = 0;
    lf    = m_lfsr[s];
    done  = 1'b0;
    for (int t = 0; t < mt[s]; t++) begin
      if (!done) begin
        lf    = lfsr_next(lf);
        c     = lf[6:0];
        e.lat = 1 + 2 * (t + 1);
        if ((int'(c) > lo[s]) && (int'(c) < hi[s]) && c[0]) begin
          e.err  = 1'b0;
          e.data = c;
          done   = 1'b1;
          m_rej[s] += t;
        end else if (t == mt[s] - 1) begin
          m_rej[s] += mt[s];
        end
      end
    end
    m_lfsr[s] = lf;
    sb.push_back(e);

    set_req(r);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_after_grant", 32'(o_busy), 32'd1);
        if (drop) set_req(2'b00);
      end
    end while (!o_valid && lat < 100);
    if (!o_valid) check("rsp_timeout", 32'(o_valid), 32'd1);

    got = sb.pop_front();
    check("rsp_id", 32'(o_id), 32'(got.id));
    check("rsp_err", 32'(o_err), 32'(got.err));
    check("rsp_data", 32'(o_data), 32'(got.data));
    check("latency", 32'(lat), 32'(got.lat));
    if (!o_err && !sel)
      check("data_odd_in_35_65", 32'((o_data >= 7'd35) && (o_data <= 7'd65) && o_data[0]), 32'd1);

    d0  = o_data;
    id0 = o_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", 32'(o_data), 32'(d0));
      check("hold_id", 32'(o_id), 32'(id0));
    end

    set_rdy(1'b1);
    @(negedge clk);
    check("valid_after_accept", 32'(o_valid), 32'd0);
    check("busy_after_accept", 32'(o_busy), 32'd0);
    set_rdy(1'b0);
    set_req(2'b00);
    m_last[s] = got.id;
`ifdef ODD_RANGE_STATS_EN
    exp_rej = (m_rej[s] > 65535) ? 65535 : m_rej[s];
`else
    exp_rej = 0;
`endif
    check("reject_cnt", 32'(o_rej), 32'(exp_rej));
  endtask

  initial begin
    rst_n = 1'b0;
    req_d = 2'b00; req_e = 2'b00;
    rdy_d = 1'b0;  rdy_e = 1'b0;
    sel   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(v_d), 32'd0);
    check("reset_busy", 32'(busy_d), 32'd0);
    check("reset_id_err_data", {23'd0, id_d, err_d, data_d}, 32'd0);
    check("reset_reject_cnt", 32'(rej_d), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesting: alternating grants starting with requester 0
    for (int i = 0; i < 4; i++) run_req(2'b11, 0, 1'b0);
    run_req(2'b01, 0, 1'b0);
    run_req(2'b10, 0, 1'b1);
    run_req(2'b01, 5, 1'b0);
    run_req(2'b11, 2, 1'b0);

    // Empty range: always exhausted after 4 draws
    sel = 1'b1;
    run_req(2'b01, 0, 1'b0);
    run_req(2'b10, 3, 1'b0);
    run_req(2'b11, 0, 1'b0);

    // Reset asserted while in CHECK aborts the request
    sel = 1'b0;
    req_d = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("midop_no_valid", 32'(v_d), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midop_reset_valid", 32'(v_d), 32'd0);
    check("midop_reset_busy", 32'(busy_d), 32'd0);
    check("midop_reset_id_err_data", {23'd0, id_d, err_d, data_d}, 32'd0);
    check("midop_reset_reject_cnt", 32'(rej_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_d = 2'b00;
    model_reset();
    @(negedge clk);
    run_req(2'b01, 0, 1'b0);
    run_req(2'b11, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      run_req(r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
